// File: rtl/ssd_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver fed by a shifting history of 4-bit digit codes.
// Guard blank at the start of each dwell and an optional whole-display blink.
module ssd_scan_driver #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int NUM_DIGITS = 4,
  parameter int GUARD_CYC  = 16,
  parameter int BLINK_HZ   = 2,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [3:0]            code,
  input  logic                  clear,
  input  logic                  blink_en,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IDX_W     = $clog2(NUM_DIGITS);
  localparam logic POL     = (ACTIVE_LOW != 0);

  logic [3:0]            digit [NUM_DIGITS];
  logic [SCAN_W-1:0]     scan_cnt;
  logic [BLINK_W-1:0]    blink_cnt;
  logic [IDX_W-1:0]      idx;
  logic                  phase;
  logic [6:0]            seg_next;
  logic [NUM_DIGITS-1:0] an_next;

  function automatic logic [6:0] decode(input logic [3:0] c);
    case (c)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      4'd10:   decode = 7'h40;
      default: decode = 7'h00;
    endcase
  endfunction

  // Active-high view of what the pins should show next; blank digits keep their anode lit.
  always_comb begin
    seg_next = 7'h00;
    an_next  = '0;
    if (!((scan_cnt < SCAN_W'(GUARD_CYC)) || (blink_en && !phase))) begin
      an_next  = NUM_DIGITS'(1) << idx;
      seg_next = decode(digit[idx]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_DIGITS; k++) digit[k] <= 4'hF;
      scan_cnt  <= '0;
      blink_cnt <= '0;
      idx       <= '0;
      phase     <= 1'b1;
      seg       <= {7{POL}};
      an        <= {NUM_DIGITS{POL}};
    end else begin
      // clear wins over a coincident load, which is simply dropped
      if (clear) begin
        for (int k = 0; k < NUM_DIGITS; k++) digit[k] <= 4'hF;
      end else if (load) begin
        for (int k = NUM_DIGITS - 1; k >= 1; k--) digit[k] <= digit[k-1];
        digit[0] <= code;
      end

      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end

      // blink phase runs continuously so enabling blink joins the current phase
      if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end

      seg <= seg_next ^ {7{POL}};
      an  <= an_next ^ {NUM_DIGITS{POL}};
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver: SCAN_DIV=10, GUARD_CYC=2, BLINK_DIV=50, 4 digits, active-low pins.
module tb_ssd_scan_driver;

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] code;
  logic       clear;
  logic       blink_en;
  logic [6:0] seg;
  logic [3:0] an;

  int errors = 0;
  int checks = 0;
  int k = 0;
  logic [6:0] pins [4];

  ssd_scan_driver #(
    .CLK_HZ(1000), .SCAN_HZ(100), .NUM_DIGITS(4),
    .GUARD_CYC(2), .BLINK_HZ(10), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .code(code), .clear(clear),
    .blink_en(blink_en), .seg(seg), .an(an)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // k counts edges since reset release; output after edge k shows scan slot (k-1)%10 of dwell (k-1)/10
  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  function automatic logic [3:0] an_for(input int kk);
    logic [3:0] oh;
    if (((kk - 1) % 10) < 2) return 4'hF;
    oh = 4'b0001 << (((kk - 1) / 10) % 4);
    return ~oh;
  endfunction

  function automatic logic [6:0] seg_for(input int kk);
    if (((kk - 1) % 10) < 2) return 7'h7F;
    return pins[((kk - 1) / 10) % 4];
  endfunction

  function automatic bit visible(input int kk);
    return (((kk - 1) / 50) % 2) == 0;
  endfunction

  task automatic do_reset();
    rst = 1'b1; load = 1'b0; clear = 1'b0; blink_en = 1'b0; code = 4'd0;
    repeat (2) step();
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 4; i++) pins[i] = 7'h7F;
  endtask

  task automatic load_code(input logic [3:0] c);
    load = 1'b1; code = c;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; clear = 1'b0; blink_en = 1'b0; code = 4'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (seg !== 7'h7F || an !== 4'hF) begin
        errors++;
        $display("[TB] FAIL reset cyc%0d: seg=%h an=%b, expected seg=7f an=1111", i, seg, an);
      end
    end
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 4; i++) pins[i] = 7'h7F;
  endtask

  task automatic test_scan_walk();
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (seg !== 7'h7F || an !== an_for(k)) begin
        errors++;
        $display("[TB] FAIL scan_walk k=%0d: seg=%h an=%b, expected seg=7f an=%b", k, seg, an, an_for(k));
      end
    end
  endtask

  task automatic test_single_digit();
    do_reset();
    pins[0] = 7'h10;
    load_code(4'd9);
    for (int i = 0; i < 39; i++) begin
      step();
      checks++;
      if (seg !== seg_for(k) || an !== an_for(k)) begin
        errors++;
        $display("[TB] FAIL single_digit k=%0d: seg=%h an=%b, expected seg=%h an=%b",
                 k, seg, an, seg_for(k), an_for(k));
      end
    end
  endtask

  task automatic test_history();
    do_reset();
    load_code(4'd3);
    load_code(4'd2);
    load_code(4'd1);
    pins[0] = 7'h79; pins[1] = 7'h24; pins[2] = 7'h30; pins[3] = 7'h7F;
    for (int i = 0; i < 37; i++) begin
      step();
      checks++;
      if (seg !== seg_for(k) || an !== an_for(k)) begin
        errors++;
        $display("[TB] FAIL history k=%0d: seg=%h an=%b, expected seg=%h an=%b",
                 k, seg, an, seg_for(k), an_for(k));
      end
    end
  endtask

  task automatic test_blink();
    logic [6:0] es;
    logic [3:0] ea;
    do_reset();
    pins[0] = 7'h3F;
    blink_en = 1'b1;
    load_code(4'd10);
    for (int i = 0; i < 199; i++) begin
      step();
      es = visible(k) ? seg_for(k) : 7'h7F;
      ea = visible(k) ? an_for(k) : 4'hF;
      checks++;
      if (seg !== es || an !== ea) begin
        errors++;
        $display("[TB] FAIL blink k=%0d: seg=%h an=%b, expected seg=%h an=%b", k, seg, an, es, ea);
      end
    end
    blink_en = 1'b0;
  endtask

  task automatic test_blink_free_running();
    logic [6:0] es;
    logic [3:0] ea;
    do_reset();
    pins[0] = 7'h00;
    load_code(4'd8);
    repeat (59) step();
    blink_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) blink_en = 1'b0;
      step();
      es = (i < 10) ? 7'h7F : seg_for(k);
      ea = (i < 10) ? 4'hF : an_for(k);
      checks++;
      if (seg !== es || an !== ea) begin
        errors++;
        $display("[TB] FAIL blink_free k=%0d: seg=%h an=%b, expected seg=%h an=%b", k, seg, an, es, ea);
      end
    end
  endtask

  task automatic test_clear_priority();
    do_reset();
    load_code(4'd7);
    load_code(4'd8);
    clear = 1'b1; load = 1'b1; code = 4'd5;
    step();
    clear = 1'b0; load = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (seg !== 7'h7F || an !== an_for(k)) begin
        errors++;
        $display("[TB] FAIL clear_priority k=%0d: seg=%h an=%b, expected seg=7f an=%b", k, seg, an, an_for(k));
      end
    end
  endtask

  task automatic test_reset_mid_dwell();
    do_reset();
    load_code(4'd4);
    load_code(4'd6);
    repeat (24) step();
    checks++;
    if (an !== 4'b1011) begin
      errors++;
      $display("[TB] FAIL pre_reset_idx2 k=%0d: an=%b, expected an=1011", k, an);
    end
    rst = 1'b1;
    step();
    checks++;
    if (seg !== 7'h7F || an !== 4'hF) begin
      errors++;
      $display("[TB] FAIL reset_mid_dwell: seg=%h an=%b, expected seg=7f an=1111", seg, an);
    end
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (seg !== 7'h7F || an !== an_for(k)) begin
        errors++;
        $display("[TB] FAIL after_reset k=%0d: seg=%h an=%b, expected seg=7f an=%b", k, seg, an, an_for(k));
      end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; clear = 1'b0; blink_en = 1'b0; code = 4'd0;
    test_reset();
    test_scan_walk();
    test_single_digit();
    test_history();
    test_blink();
    test_blink_free_running();
    test_clear_priority();
    test_reset_mid_dwell();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
